// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the VGA read-side scan controller.
// The default timing is standard 640x480 at 60 Hz with a 25.175 MHz pixel clock.
package vga_pkg;

  // Sum of the four segments of one scan axis (active, front porch, sync, back porch)
  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Horizontal timing in pixel clocks
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);

  // Vertical timing in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Sync polarity: 0 means the sync pulses are driven low
  localparam bit DEF_SYNC_POL = 1'b0;

  // RAM interface widths; the address space has to cover one full visible frame
  localparam int DEF_ADDRW = 20;
  localparam int DEF_DATAW = 24;

  typedef logic [DEF_DATAW-1:0] pixel_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the undelayed timing strobes derived
// from them. All strobes are forced low while in reset or while disabled, so the
// consumer can use them directly without extra qualification.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_enable,
  output logic o_active,
  output logic o_hsync_raw,
  output logic o_vsync_raw,
  output logic o_frame_start,
  output logic o_frame_end,
  output logic o_v_blank
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // One spare code so the exclusive end of a sync window still fits when the
  // back porch is zero.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);

  localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] C_V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_run;

  assign w_h_last = (r_h_cnt == C_H_LAST);
  assign w_v_last = (r_v_cnt == C_V_LAST);

  // Strobes are only meaningful while scanning; reset is folded in so that the
  // combinational outputs are quiet for the whole reset interval, not just
  // after the counters have cleared.
  assign w_run = rstN & i_enable;

  // Raster counters: hCnt wraps every line, vCnt advances on the hCnt wrap and
  // wraps after the last line. Disabling parks both at the frame origin so the
  // next enabled cycle is the first pixel of a fresh frame.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // Undelayed timing strobes decoded from the current counter state
  always_comb begin
    o_active      = w_run && (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    o_hsync_raw   = w_run && (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
    o_vsync_raw   = w_run && (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);
    o_frame_start = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    o_frame_end   = w_run && w_h_last && w_v_last;
    o_v_blank     = w_run && (r_v_cnt >= C_V_ACT);
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Read-side sequencer for the dual-port video RAM. Walks the RAM in raster order
// during active video and re-times the returned pixels together with the syncs
// so the display sees rgb, syncs and data-valid on the same clock.
//
// The RAM captures its output on the falling edge, so a word addressed during
// cycle N is sampled here at the rising edge that ends cycle N. A single output
// register stage therefore lines everything up with one cycle of latency.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int ADDRW    = DEF_ADDRW,
  parameter int DATAW    = DEF_DATAW
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             enable,
  input  logic [DATAW-1:0] ramData,
  output logic             readEn,
  output logic [ADDRW-1:0] readPointer,
  output logic [DATAW-1:0] rgbOut,
  output logic             dataValid,
  output logic             hSync,
  output logic             vSync,
  output logic             vBlank,
  output logic             frameStart
);

  // ADDRW must be wide enough that 2**ADDRW >= H_ACTIVE*V_ACTIVE; the pointer
  // never passes the last visible pixel, so no wrap logic is needed here.

  logic w_active;
  logic w_hsync_raw;
  logic w_vsync_raw;
  logic w_frame_start;
  logic w_frame_end;
  logic w_v_blank;
  logic w_read_en;

  logic [ADDRW-1:0] r_read_ptr;
  logic [DATAW-1:0] r_rgb;
  logic             r_data_valid;
  logic             r_hsync;
  logic             r_vsync;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rstN          (rstN),
    .i_enable      (enable),
    .o_active      (w_active),
    .o_hsync_raw   (w_hsync_raw),
    .o_vsync_raw   (w_vsync_raw),
    .o_frame_start (w_frame_start),
    .o_frame_end   (w_frame_end),
    .o_v_blank     (w_v_blank)
  );

  // The active decode is already qualified by enable and reset, so it is the
  // read strobe as-is.
  assign w_read_en = w_active;

  // Raster read pointer: advances once per fetched pixel, holds through the
  // blanking intervals and is re-armed to 0 on the final cycle of each frame so
  // the next frame starts at the first RAM word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_read_ptr <= '0;
    end else if (!enable || w_frame_end) begin
      r_read_ptr <= '0;
    end else if (w_read_en) begin
      r_read_ptr <= r_read_ptr + ADDRW'(1);
    end
  end

  // Output alignment stage: pixel, valid and syncs all leave on the same edge.
  // Pixels are blanked to zero outside active video so the display never sees
  // stale RAM data in the porches.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rgb        <= '0;
      r_data_valid <= 1'b0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
    end else begin
      r_rgb        <= w_read_en ? ramData : '0;
      r_data_valid <= w_read_en;
      r_hsync      <= w_hsync_raw ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vsync_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign readEn      = w_read_en;
  assign readPointer = r_read_ptr;
  assign rgbOut      = r_rgb;
  assign dataValid   = r_data_valid;
  assign hSync       = r_hsync;
  assign vSync       = r_vsync;
  assign vBlank      = w_v_blank;
  assign frameStart  = w_frame_start;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a reduced raster (16x11 total,
// 8x6 visible) so complete frames fit in a short run. A RAM model that returns
// data = address sits on the read port.
module tb_vga_scan_ctrl;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int FT = HT * VT;             // 176 cycles per frame
  localparam int NPIX = HA * VA;           // 48 visible pixels
  localparam int AW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstN;
  logic          enable;
  logic [DW-1:0] ramData = '0;
  logic          readEn;
  logic [AW-1:0] readPointer;
  logic [DW-1:0] rgbOut;
  logic          dataValid;
  logic          hSync;
  logic          vSync;
  logic          vBlank;
  logic          frameStart;

  int checks = 0;
  int errors = 0;

  vga_scan_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .ADDRW (AW), .DATAW (DW)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .enable      (enable),
    .ramData     (ramData),
    .readEn      (readEn),
    .readPointer (readPointer),
    .rgbOut      (rgbOut),
    .dataValid   (dataValid),
    .hSync       (hSync),
    .vSync       (vSync),
    .vBlank      (vBlank),
    .frameStart  (frameStart)
  );

  always #5 clk = ~clk;

  // RAM read port: output register updates on the falling edge, data = address
  always @(negedge clk) begin
    if (readEn) ramData = DW'(readPointer);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read strobe for frame offset f
  function automatic int exp_act(input int f);
    int h, v;
    h = f % HT;
    v = f / HT;
    return ((h < HA) && (v < VA)) ? 1 : 0;
  endfunction

  // Expected pointer for frame offset f: pixels already fetched this frame
  function automatic int exp_ptr(input int f);
    int h, v;
    h = f % HT;
    v = f / HT;
    if (v < VA) return v * HA + ((h < HA) ? h : HA);
    return NPIX;
  endfunction

  initial begin
    int f, h, v, pf, ph, pv;
    int pix_idx, pix_seen, line_rd, hs_low, hs_first, vs_low, vb_cnt;
    int fs_last, fs_period, max_ptr, last_ptr_at_end;

    rstN   = 1'b0;
    enable = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_readEn", 32'(readEn), 0);
    chk("rst_readPointer", 32'(readPointer), 0);
    chk("rst_frameStart", 32'(frameStart), 0);
    chk("rst_vBlank", 32'(vBlank), 0);
    chk("rst_dataValid", 32'(dataValid), 0);
    chk("rst_rgbOut", 32'(rgbOut), 0);
    chk("rst_hSync", 32'(hSync), 1);
    chk("rst_vSync", 32'(vSync), 1);

    // Release mid-cycle so the first state spans a full RAM falling edge
    rstN = 1'b1;
    #1;
    chk("first_frameStart", 32'(frameStart), 1);
    chk("first_readEn", 32'(readEn), 1);
    chk("first_readPointer", 32'(readPointer), 0);

    pix_idx = 0; pix_seen = 0; line_rd = 0; hs_low = 0; hs_first = -1;
    vs_low = 0; vb_cnt = 0; fs_last = -1; fs_period = -1; max_ptr = -1;
    last_ptr_at_end = -1;

    // Two full frames, every cycle checked against the raster model
    for (int t = 0; t < 2 * FT; t++) begin
      f = t % FT;
      h = f % HT;
      v = f / HT;
      chk("readEn", 32'(readEn), exp_act(f));
      chk("readPointer", 32'(readPointer), exp_ptr(f));
      chk("frameStart", 32'(frameStart), (f == 0) ? 1 : 0);
      chk("vBlank", 32'(vBlank), (v >= VA) ? 1 : 0);
      if (t > 0) begin
        pf = (t - 1) % FT;
        ph = pf % HT;
        pv = pf / HT;
        chk("dataValid", 32'(dataValid), exp_act(pf));
        chk("rgbOut", 32'(rgbOut), (exp_act(pf) != 0) ? exp_ptr(pf) : 0);
        chk("hSync", 32'(hSync), (ph >= HA + HF && ph < HA + HF + HS) ? 0 : 1);
        chk("vSync", 32'(vSync), (pv >= VA + VF && pv < VA + VF + VS) ? 0 : 1);
      end
      if (dataValid === 1'b1) begin
        chk("raster_seq", 32'(rgbOut), pix_idx);
        pix_idx = (pix_idx + 1) % NPIX;
        pix_seen++;
      end
      if (t < HT && readEn === 1'b1) line_rd++;
      if (t >= 1 && t <= HT && hSync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = t;
      end
      if (t >= 1 && t <= FT && vSync === 1'b0) vs_low++;
      if (t < FT && vBlank === 1'b1) vb_cnt++;
      if (frameStart === 1'b1) begin
        if (fs_last >= 0) fs_period = t - fs_last;
        fs_last = t;
      end
      if (readEn === 1'b1 && int'(readPointer) > max_ptr) max_ptr = int'(readPointer);
      if (f == FT - 1) last_ptr_at_end = int'(readPointer);
      tick();
    end

    chk("line_read_cycles", 32'(line_rd), HA);
    chk("hsync_low_cycles", 32'(hs_low), HS);
    chk("hsync_first_low", 32'(hs_first), HA + HF + 1);
    chk("vsync_low_cycles", 32'(vs_low), VS * HT);
    chk("vblank_cycles", 32'(vb_cnt), (VT - VA) * HT);
    chk("frame_period", 32'(fs_period), FT);
    chk("last_active_ptr", 32'(max_ptr), NPIX - 1);
    chk("ptr_held_in_blank", 32'(last_ptr_at_end), NPIX);
    chk("pixels_two_frames", 32'(pix_seen), 2 * NPIX);
    chk("next_frame_ptr", 32'(readPointer), 0);
    chk("next_frame_start", 32'(frameStart), 1);

    // Disable mid-line at hCnt=3, vCnt=2
    repeat (2 * HT + 3) tick();
    chk("pre_dis_readPointer", 32'(readPointer), 2 * HA + 3);
    chk("pre_dis_readEn", 32'(readEn), 1);
    enable = 1'b0;
    #1;
    chk("dis_readEn_now", 32'(readEn), 0);
    chk("dis_frameStart", 32'(frameStart), 0);
    tick();
    chk("dis_readPointer", 32'(readPointer), 0);
    chk("dis_dataValid", 32'(dataValid), 0);
    chk("dis_hSync", 32'(hSync), 1);
    chk("dis_vSync", 32'(vSync), 1);
    chk("dis_vBlank", 32'(vBlank), 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("dis_hold_readEn", 32'(readEn), 0);
      chk("dis_hold_rgbOut", 32'(rgbOut), 0);
      chk("dis_hold_frameStart", 32'(frameStart), 0);
    end
    enable = 1'b1;
    #1;
    chk("reen_frameStart", 32'(frameStart), 1);
    chk("reen_readEn", 32'(readEn), 1);
    chk("reen_readPointer", 32'(readPointer), 0);
    tick();
    chk("reen_ptr1", 32'(readPointer), 1);
    chk("reen_dataValid", 32'(dataValid), 1);
    chk("reen_rgb0", 32'(rgbOut), 0);
    chk("reen_frameStart_gone", 32'(frameStart), 0);
    tick();
    chk("reen_rgb1", 32'(rgbOut), 1);

    // Asynchronous reset between edges during active video (hCnt=4)
    repeat (2) tick();
    chk("pre_rst_rgbOut", 32'(rgbOut), 3);
    chk("pre_rst_readPointer", 32'(readPointer), 4);
    #2;
    rstN = 1'b0;
    #1;
    chk("arst_readPointer", 32'(readPointer), 0);
    chk("arst_dataValid", 32'(dataValid), 0);
    chk("arst_rgbOut", 32'(rgbOut), 0);
    chk("arst_readEn", 32'(readEn), 0);
    chk("arst_frameStart", 32'(frameStart), 0);
    chk("arst_hSync", 32'(hSync), 1);
    chk("arst_vSync", 32'(vSync), 1);
    tick();
    rstN = 1'b1;
    #1;
    chk("rel_frameStart", 32'(frameStart), 1);
    chk("rel_readPointer", 32'(readPointer), 0);
    tick();
    chk("rel_ptr1", 32'(readPointer), 1);
    chk("rel_dataValid", 32'(dataValid), 1);
    chk("rel_rgb0", 32'(rgbOut), 0);
    tick();
    chk("rel_rgb1", 32'(rgbOut), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Read-side sequencer for the dual-port video RAM.
- Runs the VGA horizontal/vertical timing counters and drives the RAM read enable and read pointer in raster order.
- Re-aligns the returned pixel data with delayed sync/data-enable so the display output sees matched rgb, hSync, vSync and dataValid.
- Exports blanking/frame markers so the write side can schedule frame updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hSync/vSync (0 = active-low)
- ADDRW, 20, read pointer width; must satisfy 2^ADDRW >= H_ACTIVE*V_ACTIVE
- DATAW, 24, pixel width

Ports:
- clk  in  1  pixel clock; also drives the RAM read clock
- rstN  in  1  asynchronous active-low reset
- enable  in  1  scan enable; low forces the idle state
- ramData  in  DATAW  pixel returned from RAM
- readEn  out  1  RAM read enable
- readPointer  out  ADDRW  RAM read address
- rgbOut  out  DATAW  pixel to display; zero when not valid
- dataValid  out  1  active-video strobe, aligned with rgbOut
- hSync  out  1  horizontal sync, aligned with rgbOut
- vSync  out  1  vertical sync, aligned with rgbOut
- vBlank  out  1  high while vCnt >= V_ACTIVE (undelayed)
- frameStart  out  1  one-cycle pulse when hCnt=0, vCnt=0 (undelayed)

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525).
- Counters:
  - hCnt counts 0..H_TOTAL-1 and wraps to 0.
  - vCnt increments when hCnt wraps and itself wraps after V_TOTAL-1.
- Active region: active = (hCnt < H_ACTIVE) && (vCnt < V_ACTIVE).
- Read control: readEn = active && enable, combinational from the counters.
- readPointer register:
  - Starts at 0.
  - Increments by 1 on every cycle with readEn=1.
  - Loads 0 on the last cycle of the frame (hCnt=H_TOTAL-1, vCnt=V_TOTAL-1).
  - Never exceeds H_ACTIVE*V_ACTIVE-1 (307199) while readEn is high.
  - Holds its value during blanking.
- RAM latency: the RAM registers its output on the falling clock edge. Data addressed at rising edge N is therefore stable for sampling at rising edge N+1.
- Output pipeline (1 stage, registered at posedge):
  - dataValid <= readEn.
  - rgbOut <= readEn ? ramData : 0.
  - hSync/vSync are likewise registered from the undelayed syncs.
  - Net latency from counter state to all display outputs is 1 cycle.
- Sync windows (before SYNC_POL is applied):
  - hsyncRaw = H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsyncRaw = V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Output level is hsyncRaw ? SYNC_POL : !SYNC_POL; same for vSync.
- enable low:
  - hCnt, vCnt and readPointer are cleared to 0 on the next edge; readEn=0.
  - Syncs go inactive one cycle later; rgbOut=0, dataValid=0.
  - frameStart and vBlank are forced low.
- enable rising: scanning begins at hCnt=0, vCnt=0. frameStart pulses on the first enabled cycle.
- Reset (rstN low, any time, including mid-line):
  - Counters, readPointer, rgbOut and dataValid clear to 0 immediately.
  - hSync and vSync go to the inactive level (!SYNC_POL).
  - frameStart=0, vBlank=0, readEn=0.
  - After release, behaviour is identical to an enable rising edge.
- Wrap boundaries: hCnt=H_TOTAL-1 with vCnt=V_TOTAL-1 wraps both counters in the same cycle.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_ACTIVE..V_BP, derived H_TOTAL/V_TOTAL);
  - ADDRW/DATAW defaults;
  - typedef pixel_t (logic [DATAW-1:0]).
- One sub-module, vga_timing_gen:
  - contains the hCnt/vCnt counters and emits active, hsyncRaw, vsyncRaw, frameStart and vBlank;
  - vga_scan_ctrl adds the pointer, RAM interface and alignment pipeline.

Test Plan:
- Default params, reset release with enable=1:
  - first edge: frameStart=1, readEn=1, readPointer=0;
  - one cycle later: dataValid=1, rgbOut equals ramData returned for address 0.
- Line timing:
  - readEn high for exactly 640 cycles per line, then low for 160;
  - hSync low for exactly 96 cycles, starting 656 cycles after line start plus 1-cycle latency.
- Frame timing:
  - vSync low on lines 490-491 only;
  - vBlank high for lines 480-524;
  - last active read uses readPointer=307199;
  - the next frame's first read uses 0;
  - frame period is 420000 cycles.
- Behavioural RAM model with data = address:
  - every rgbOut sample with dataValid=1 equals the expected raster index;
  - no gaps or duplicates across 2 full frames.
- Deassert enable mid-line (hCnt=300, vCnt=100), re-enable 10 cycles later:
  - readEn=0 and rgbOut=0 while disabled;
  - restart at hCnt=0, readPointer=0, with a frameStart pulse.
- Assert rstN=0 asynchronously mid-active (between edges):
  - outputs clear immediately, without waiting for a clock edge;
  - syncs inactive (high with SYNC_POL=0);
  - after release, frame restarts from readPointer=0.
